// File: rtl/audvid_pkg.sv
// Shared AudVid audio definitions: frame layout and packer byte order, also used by the I2S side.
package audvid_pkg;

  localparam int unsigned AUDIO_FRAME_W = 32;
  localparam int unsigned AUDIO_CH_W    = 16;

  // Packer byte index: little-endian within each channel, left channel first.
  localparam logic [1:0] BYTE_L_LO = 2'd0;
  localparam logic [1:0] BYTE_L_HI = 2'd1;
  localparam logic [1:0] BYTE_R_LO = 2'd2;
  localparam logic [1:0] BYTE_R_HI = 2'd3;

  typedef struct packed {
    logic [AUDIO_CH_W-1:0] left;
    logic [AUDIO_CH_W-1:0] right;
  } audio_frame_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous strobe, followed by a registered rising-edge pulse.
module edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/audio_sample_fifo.sv
// Packs SD-card audio bytes into 32-bit stereo frames and buffers them in a circular FIFO for I2S.
module audio_sample_fifo
  import audvid_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2         = 6,
  parameter int unsigned ALMOST_FULL_MARGIN = 4
) (
  input  logic                     MasterCLK,
  input  logic                     Reset,
  input  logic [7:0]               SD_InputData,
  input  logic                     SD_InputDataClock,
  input  logic                     SD_EnableDataRead,
  input  logic                     AudioEnable,
  input  logic                     Flush,
  input  logic                     SyncCLK,
  output logic [AUDIO_FRAME_W-1:0] SampleData,
  output logic [DEPTH_LOG2:0]      Level,
  output logic                     Empty,
  output logic                     AlmostFull,
  output logic                     Overrun,
  output logic                     Underrun
);

  localparam int unsigned PtrW  = DEPTH_LOG2;
  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;
  localparam int unsigned Slots = 2 ** DEPTH_LOG2;
  localparam logic [LvlW-1:0] Depth  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LvlW-1:0] Margin = LvlW'(ALMOST_FULL_MARGIN);

  logic w_byte_stb;
  logic w_req_stb;

  edge_sync u_byte_sync (
    .i_clk   (MasterCLK),
    .i_rst_n (Reset),
    .i_async (SD_InputDataClock),
    .o_pulse (w_byte_stb)
  );

  edge_sync u_req_sync (
    .i_clk   (MasterCLK),
    .i_rst_n (Reset),
    .i_async (SyncCLK),
    .o_pulse (w_req_stb)
  );

  // Data and enable ride a three-stage path so they line up with the byte pulse.
  logic [8:0] r_sd_s1;
  logic [8:0] r_sd_s2;
  logic [8:0] r_sd_s3;

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      r_sd_s1 <= '0;
      r_sd_s2 <= '0;
      r_sd_s3 <= '0;
    end else begin
      r_sd_s1 <= {SD_EnableDataRead, SD_InputData};
      r_sd_s2 <= r_sd_s1;
      r_sd_s3 <= r_sd_s2;
    end
  end

  logic [1:0]               r_idx;
  logic [23:0]              r_hold;
  logic [PtrW-1:0]          r_wr_ptr;
  logic [PtrW-1:0]          r_rd_ptr;
  logic [LvlW-1:0]          r_level;
  logic [AUDIO_FRAME_W-1:0] r_sample;
  logic                     r_overrun;
  logic                     r_underrun;
  logic [AUDIO_FRAME_W-1:0] r_mem [Slots];

  logic         w_byte_ok;
  logic         w_frame_done;
  logic         w_full;
  logic         w_empty;
  logic         w_wr;
  logic         w_rd_ok;
  audio_frame_t w_frame;

  always_comb begin
    w_byte_ok    = w_byte_stb & r_sd_s3[8] & AudioEnable;
    w_frame_done = w_byte_ok & (r_idx == BYTE_R_HI);
    w_full       = (r_level == Depth);
    w_empty      = (r_level == '0);
    // A coincident pop frees the slot, so a full FIFO still accepts the frame.
    w_wr         = w_frame_done & (~w_full | w_req_stb);
    w_rd_ok      = w_req_stb & ~w_empty;
    w_frame.left  = r_hold[15:0];
    w_frame.right = {r_sd_s3[7:0], r_hold[23:16]};
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < Slots; i++) r_mem[i] <= '0;
    end else if (!Flush && w_wr) begin
      r_mem[r_wr_ptr] <= w_frame;
    end
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      r_idx      <= '0;
      r_hold     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_sample   <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else if (Flush) begin
      r_idx      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_sample   <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_byte_ok) begin
        case (r_idx)
          BYTE_L_LO: r_hold[7:0]   <= r_sd_s3[7:0];
          BYTE_L_HI: r_hold[15:8]  <= r_sd_s3[7:0];
          BYTE_R_LO: r_hold[23:16] <= r_sd_s3[7:0];
          default:   ;
        endcase
        r_idx <= r_idx + 2'd1;
      end
      if (w_wr) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_frame_done && !w_wr) r_overrun <= 1'b1;
      if (w_req_stb) begin
        if (w_rd_ok) begin
          r_sample <= r_mem[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + PtrW'(1);
        end else begin
          r_sample   <= '0;
          r_underrun <= 1'b1;
        end
      end
      case ({w_wr, w_rd_ok})
        2'b10:   r_level <= r_level + LvlW'(1);
        2'b01:   r_level <= r_level - LvlW'(1);
        default: ;
      endcase
    end
  end

  assign SampleData = r_sample;
  assign Level      = r_level;
  assign Empty      = w_empty;
  assign AlmostFull = ((Depth - r_level) <= Margin);
  assign Overrun    = r_overrun;
  assign Underrun   = r_underrun;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: packing, FIFO limits, underrun/overrun, flush and reset.
module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sd_data;
  logic        sd_clk;
  logic        sd_en;
  logic        audio_en;
  logic        flush;
  logic        sync_clk;
  logic [31:0] sample;
  logic [6:0]  level;
  logic        empty;
  logic        almost_full;
  logic        overrun;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  audio_sample_fifo dut (
    .MasterCLK         (clk),
    .Reset             (rst_n),
    .SD_InputData      (sd_data),
    .SD_InputDataClock (sd_clk),
    .SD_EnableDataRead (sd_en),
    .AudioEnable       (audio_en),
    .Flush             (flush),
    .SyncCLK           (sync_clk),
    .SampleData        (sample),
    .Level             (level),
    .Empty             (empty),
    .AlmostFull        (almost_full),
    .Overrun           (overrun),
    .Underrun          (underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Strobe held high three cycles and low three cycles; outputs settled on return.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    sd_data = b;
    sd_clk  = 1'b1;
    repeat (3) @(negedge clk);
    sd_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_frame(input logic [31:0] f);
    send_byte(f[23:16]);
    send_byte(f[31:24]);
    send_byte(f[7:0]);
    send_byte(f[15:8]);
  endtask

  task automatic pop;
    @(negedge clk);
    sync_clk = 1'b1;
    repeat (3) @(negedge clk);
    sync_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_flush;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  function automatic logic [31:0] frame_of(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {8'hA5, kb, 8'h5A, kb};
  endfunction

  initial begin
    rst_n    = 1'b0;
    sd_data  = 8'h00;
    sd_clk   = 1'b0;
    sd_en    = 1'b1;
    audio_en = 1'b1;
    flush    = 1'b0;
    sync_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sample", sample, 32'h0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_udr", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pop while empty.
    pop();
    check("udr_sample", sample, 32'h0);
    check("udr_flag", 32'(underrun), 32'd1);
    check("udr_level", 32'(level), 32'd0);
    do_flush();
    check("flush_udr", 32'(underrun), 32'd0);

    // Basic packing with latency check on the 4th byte.
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h78);
    @(negedge clk);
    sd_data = 8'h56;
    sd_clk  = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_before", 32'(level), 32'd0);
    @(negedge clk);
    check("lat_after", 32'(level), 32'd1);
    sd_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("pack_empty", 32'(empty), 32'd0);
    pop();
    check("pack_sample", sample, 32'h12345678);
    check("pack_level", 32'(level), 32'd0);
    check("pack_empty2", 32'(empty), 32'd1);
    check("pack_udr", 32'(underrun), 32'd0);

    // Disabled SD qualifier: byte ignored.
    sd_en = 1'b0;
    send_byte(8'hEE);
    sd_en = 1'b1;

    // Fill to 64 frames.
    for (int k = 1; k <= 64; k++) begin
      push_frame(frame_of(k));
      if (k == 59) check("af_59", 32'(almost_full), 32'd0);
      if (k == 60) check("af_60", 32'(almost_full), 32'd1);
    end
    check("full_level", 32'(level), 32'd64);
    check("full_ovr", 32'(overrun), 32'd0);

    // Full FIFO: 4th byte and pop request in the same cycle.
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    @(negedge clk);
    sd_data  = 8'h00;
    sd_clk   = 1'b1;
    sync_clk = 1'b1;
    repeat (3) @(negedge clk);
    sd_clk   = 1'b0;
    sync_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("sim_level", 32'(level), 32'd64);
    check("sim_ovr", 32'(overrun), 32'd0);
    check("sim_sample", sample, frame_of(1));

    // 65th frame is dropped.
    push_frame(32'hDEADBEEF);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_level", 32'(level), 32'd64);
    for (int k = 2; k <= 64; k++) begin
      pop();
      check("drain", sample, frame_of(k));
    end
    pop();
    check("drain_last", sample, 32'h22330011);
    check("drain_empty", 32'(empty), 32'd1);
    pop();
    check("drain_udr_sample", sample, 32'h0);

    // AudioEnable low mid-frame holds the packer.
    do_flush();
    send_byte(8'h11);
    send_byte(8'h22);
    audio_en = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    audio_en = 1'b1;
    send_byte(8'h66);
    check("aen_partial", 32'(level), 32'd0);
    send_byte(8'h77);
    check("aen_level", 32'(level), 32'd1);
    pop();
    check("aen_sample", sample, 32'h22117766);
    pop();
    check("aen_udr", 32'(underrun), 32'd1);

    // Flush with 10 frames and a half-built frame.
    for (int k = 1; k <= 10; k++) push_frame(frame_of(k + 100));
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("pre_flush_level", 32'(level), 32'd10);
    do_flush();
    check("flush_level", 32'(level), 32'd0);
    check("flush_udr2", 32'(underrun), 32'd0);
    check("flush_sample", sample, 32'h0);
    push_frame(32'h0BADF00D);
    check("post_flush_level", 32'(level), 32'd1);
    pop();
    check("post_flush_sample", sample, 32'h0BADF00D);

    // Asynchronous reset mid-frame.
    push_frame(32'hCAFEBABE);
    pop();
    push_frame(32'h01020304);
    send_byte(8'h99);
    send_byte(8'h88);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sample", sample, 32'h0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_frame(32'h76543210);
    pop();
    check("arst_repack", sample, 32'h76543210);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Audio staging buffer between the SD card reader (SD_SPI) and the I2S DAC transmitter in the AudVid peripheral. Captures track bytes from the SD reader once tile loading is finished, packs each group of four bytes into one 32-bit stereo frame, and stores frames in a circular FIFO. It hands one frame to I2S on each I2S frame request, emitting silence and flagging underrun when empty.

## Interface
Parameters:
- DEPTH_LOG2, default 6: FIFO holds 2^DEPTH_LOG2 frames (64).
- ALMOST_FULL_MARGIN, default 4: AlmostFull asserts when free slots ≤ this value.

Ports:
- MasterCLK  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- SD_InputData  in  8  byte from SD reader, stable around SD_InputDataClock rising edge.
- SD_InputDataClock  in  1  SD reader byte strobe; asynchronous to MasterCLK; one byte per rising edge.
- SD_EnableDataRead  in  1  SD reader data-valid qualifier; synchronised alongside the strobe.
- AudioEnable  in  1  level; 1 = bytes are audio and are consumed; 0 = bytes ignored (tile phase).
- Flush  in  1  synchronous clear of FIFO and packer.
- SyncCLK  in  1  I2S frame request; asynchronous; one frame popped per rising edge.
- SampleData  out  32  {Left[15:0], Right[15:0]} presented to I2S.
- Level  out  DEPTH_LOG2+1  frames stored.
- Empty  out  1  Level == 0.
- AlmostFull  out  1  free slots ≤ ALMOST_FULL_MARGIN.
- Overrun  out  1  sticky: a completed frame was dropped because FIFO was full.
- Underrun  out  1  sticky: a request arrived while empty.

## Operation
- Both asynchronous strobes pass through a 2-flop synchroniser plus rising-edge detect, producing one-cycle internal pulses: byte_stb and req_stb. SD_EnableDataRead and SD_InputData are registered on the same path as SD_InputDataClock.
- Byte accepted when byte_stb && synchronised SD_EnableDataRead && AudioEnable. Otherwise the byte is ignored and the packer is unchanged.
- Packer: 2-bit byte index, little-endian per channel: byte0→L[7:0], byte1→L[15:8], byte2→R[7:0], byte3→R[15:8]. Index wraps 3→0.
- On the 4th byte, the frame is assembled from the 24 held bits plus the incoming byte and is written the same cycle. If the FIFO is full, the frame is dropped, Overrun is set, and the index still wraps.
- Pop on req_stb: if not empty, SampleData ← head frame and the read pointer advances. If empty, SampleData ← 0 (silence) and Underrun is set.
- Simultaneous write and pop: both occur and Level is unchanged. With the FIFO full, a write that coincides with a pop succeeds and Overrun stays clear. With the FIFO empty, a coincident write is not bypassed: the pop returns silence and sets Underrun.
- Pointers are DEPTH_LOG2 bits with natural wrap. Level is a separate counter of DEPTH_LOG2+1 bits, saturating at 2^DEPTH_LOG2.
- AudioEnable falling mid-frame holds the packer index. The partial frame resumes when AudioEnable returns.
- Flush: pointers, Level, packer index, Overrun, Underrun and SampleData are cleared next cycle. A byte or request coinciding with Flush is discarded. Flush has priority.
- Reset (asynchronous assert, removal on MasterCLK): every register is 0, including the synchroniser flops. SampleData = 0, Level = 0, Empty = 1, AlmostFull = 0, Overrun = 0, Underrun = 0.

## Timing
- SD_InputDataClock rising edge → byte_stb after 3 MasterCLK edges (2 sync + edge detect). A 4th byte reaches Level/Empty 1 edge after byte_stb (4 total).
- SyncCLK rising edge → SampleData updated 4 MasterCLK edges later. SampleData then holds until the next pop.
- Strobes must be high and low for ≥2 MasterCLK periods each. Faster strobes may be lost and this is not detected.
- Outputs are registered except Empty and AlmostFull, which decode combinationally from registered Level.
- Storage is a register array; reads are from the registered head.

## Structure
- Shared package audvid_pkg: AUDIO_FRAME_W = 32, AUDIO_CH_W = 16, and byte-index constants for the packing order. These are also used by I2S.
- Sub-module edge_sync (2-flop synchroniser + rising-edge pulse, async active-low reset), instantiated twice.
- Everything else is in audio_sample_fifo.

## Test plan
- Reset, AudioEnable = 1, bytes 0x34, 0x12, 0x78, 0x56 → Level = 1. Next SyncCLK edge → SampleData = 0x12345678, Level = 0, Empty = 1.
- SyncCLK with FIFO empty after reset → SampleData = 0x00000000, Underrun = 1, Level stays 0.
- Push 65 frames without pops (DEPTH_LOG2 = 6) → Level = 64, AlmostFull = 1 from Level 60, Overrun = 1, 65th frame absent. The first pop returns frame 1.
- Full FIFO, 4th byte_stb and req_stb in the same cycle → Level stays 64, Overrun = 0, the popped value is the oldest frame.
- Two bytes, AudioEnable low for 3 bytes, high, two more bytes → exactly one frame formed from bytes 1, 2, 6, 7.
- Flush with Level = 10 and packer index 2, then 4 new bytes → Level = 1, the frame contains only the new bytes, stickies cleared. Async Reset mid-frame → all outputs 0 immediately.
